// File: rtl/stream_mux_rr_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Producer/consumer bundle of the multiplexer; slave is the mux side, master the environment side.
interface stream_mux_rr_if
   import stream_mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 4
) ();

   localparam int SEL_W = sel_w(N);

   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_last;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_last;
   logic [SEL_W-1:0]   out_sel;
   logic               out_ready;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_last, out_sel
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_last, out_sel
   );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr_i, wrapping modulo N.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]          req_i,
   input  logic [sel_w(N)-1:0]   ptr_i,
   output logic [N-1:0]          grant_oh_o,
   output logic [sel_w(N)-1:0]   grant_idx_o,
   output logic                  any_o
);

   localparam int SEL_W = sel_w(N);

   int idx;

   always_comb begin
      grant_oh_o  = '0;
      grant_idx_o = '0;
      any_o       = 1'b0;
      idx         = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr_i) + k) % N;
         if (!any_o && req_i[idx]) begin
            any_o           = 1'b1;
            grant_oh_o[idx] = 1'b1;
            grant_idx_o     = SEL_W'(idx);
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream merger with round-robin arbitration and optional packet lock.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int N        = 4,
   parameter int LOCK_PKT = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   stream_mux_rr_if.slave bus
);

   localparam int SEL_W = sel_w(N);

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;
   logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               out_last_q, out_last_d;
   logic [SEL_W-1:0]   out_sel_q, out_sel_d;

   logic [N-1:0]       grant_oh;
   logic [SEL_W-1:0]   grant_idx;
   logic               any_req;
   logic [N-1:0]       in_ready;
   logic [SEL_W-1:0]   cur_ch;
   logic               slot_free;
   logic               xfer;
   logic               cur_last;

   rr_arbiter #(.N(N)) u_arb (
      .req_i       (bus.in_valid),
      .ptr_i       (rr_ptr_q),
      .grant_oh_o  (grant_oh),
      .grant_idx_o (grant_idx),
      .any_o       (any_req)
   );

   always_comb begin
      slot_free   = !out_valid_q || bus.out_ready;
      cur_ch      = (state_q == LOCKED) ? lock_ch_q : grant_idx;
      in_ready    = '0;
      // Nobody is accepted during reset, nor while a held output beat blocks the slot.
      if (rst_n) begin
         if (state_q == LOCKED) in_ready[lock_ch_q] = slot_free;
         else if (any_req)      in_ready = grant_oh & {N{slot_free}};
      end
      xfer        = |(in_ready & bus.in_valid);
      cur_last    = bus.in_last[cur_ch];

      state_d     = state_q;
      lock_ch_d   = lock_ch_q;
      rr_ptr_d    = rr_ptr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_sel_d   = out_sel_q;

      if (xfer) begin
         out_data_d  = bus.in_data[int'(cur_ch)*WIDTH +: WIDTH];
         out_valid_d = 1'b1;
         out_last_d  = cur_last;
         out_sel_d   = cur_ch;
         case (state_q)
            IDLE: begin
               rr_ptr_d = grant_idx;
               if ((LOCK_PKT != 0) && !cur_last) begin
                  state_d   = LOCKED;
                  lock_ch_d = grant_idx;
               end
            end
            LOCKED: if (cur_last) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lock_ch_q   <= '0;
         rr_ptr_q    <= SEL_W'(N - 1);
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_sel_q   <= '0;
      end else begin
         state_q     <= state_d;
         lock_ch_q   <= lock_ch_d;
         rr_ptr_q    <= rr_ptr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_sel   = out_sel_q;

endmodule
